// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the iterative ALU.
// Holds the opcode class field values, the full 6-bit opcode constants
// (class in [5:4], operation in [3:0]) and the controller state type.
package alu_pkg;

  // Opcode class field, opCode[5:4]
  localparam logic [1:0] CLS_ARITH = 2'b01;
  localparam logic [1:0] CLS_REL   = 2'b10;
  localparam logic [1:0] CLS_MUL   = 2'b11;

  // Full opcodes
  localparam logic [5:0] OP_ADD = {CLS_ARITH, 4'b0000};
  localparam logic [5:0] OP_SUB = {CLS_ARITH, 4'b0001};
  localparam logic [5:0] OP_EQ  = {CLS_REL,   4'b0000};
  localparam logic [5:0] OP_LT  = {CLS_REL,   4'b0001};
  localparam logic [5:0] OP_LTU = {CLS_REL,   4'b0010};
  localparam logic [5:0] OP_MUL = {CLS_MUL,   4'b0000};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } stateT;

endpackage

// File: rtl/mul_shift_add.sv
// mul_shift_add: iterative unsigned shift-add multiplier, one partial
// product per cycle. Only built when ALU_ITER_MUL_EN is defined.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   start       load a/b and begin (one-cycle pulse)
//   a, b        WIDTH-bit operands, sampled on the start edge
//   done        high for one cycle once STEPS steps have completed
//   product     2*WIDTH-bit result, valid while done is high
`ifdef ALU_ITER_MUL_EN
module mul_shift_add #(
  parameter int WIDTH = 32,
  parameter int STEPS = WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(STEPS + 1);

  logic [CW-1:0]      cntR;
  logic               runR;
  logic [2*WIDTH-1:0] accR;
  logic [2*WIDTH-1:0] mcandR;
  logic [WIDTH-1:0]   mplierR;

  assign done    = runR && (cntR == CW'(STEPS));
  assign product = accR;

  // Operand load and one shift-add step per cycle while running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cntR    <= {CW{1'b0}};
      runR    <= 1'b0;
      accR    <= {(2*WIDTH){1'b0}};
      mcandR  <= {(2*WIDTH){1'b0}};
      mplierR <= {WIDTH{1'b0}};
    end else if (start) begin
      cntR    <= {CW{1'b0}};
      runR    <= 1'b1;
      accR    <= {(2*WIDTH){1'b0}};
      mcandR  <= {{WIDTH{1'b0}}, a};
      mplierR <= b;
    end else if (done) begin
      runR <= 1'b0;
    end else if (runR) begin
      // Add the shifted multiplicand when the current multiplier bit is set
      if (mplierR[0]) begin
        accR <= accR + mcandR;
      end else begin
        accR <= accR;
      end
      mcandR  <= {mcandR[2*WIDTH-2:0], 1'b0};
      mplierR <= {1'b0, mplierR[WIDTH-1:1]};
      cntR    <= cntR + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      runR <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/alu_iter.sv
// alu_iter: valid/ready ALU with single-cycle add/sub/compare and an
// optional iterative multiply.
// Build option: ALU_ITER_MUL_EN enables MUL (opcode 110000) through the
// mul_shift_add sub-module; without it that opcode is reported as illegal.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   operand handshake (ready only when idle)
//   a, b                  WIDTH-bit operands
//   opCode                [5:4] class, [3:0] operation
//   cOptional             carry-in (ADD) / borrow-in (SUB)
//   out_valid / out_ready result handshake
//   ans                   WIDTH-bit result
//   ansOptional           carry-out / borrow-out / multiply overflow
//   z, n, err             zero, negative, illegal-opcode flags
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       opCode,
  input  logic             cOptional,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ans,
  output logic             ansOptional,
  output logic             z,
  output logic             n,
  output logic             err
);

  stateT            stateR, stateNext;
  logic             loadRes;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] aluAns, nextAns;
  logic             aluOpt, aluErr, nextOpt, nextErr;
  logic [WIDTH-1:0] ansR;
  logic             optR, zR, nR, errR;

`ifdef ALU_ITER_MUL_EN
  localparam int MUL_CYCLES = WIDTH;

  logic               mulStart;
  logic               mulDone;
  logic [2*WIDTH-1:0] product;

  assign mulStart = (stateR == IDLE) && in_valid && (opCode == OP_MUL);

  mul_shift_add #(
    .WIDTH(WIDTH),
    .STEPS(MUL_CYCLES)
  ) uMul (
    .clk    (clk),
    .rst    (rst),
    .start  (mulStart),
    .a      (a),
    .b      (b),
    .done   (mulDone),
    .product(product)
  );
`endif

  assign in_ready    = (stateR == IDLE);
  assign out_valid   = (stateR == DONE);
  assign ans         = ansR;
  assign ansOptional = optR;
  assign z           = zR;
  assign n           = nR;
  assign err         = errR;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateR <= IDLE;
    end else begin
      stateR <= stateNext;
    end
  end

  // Next-state logic and result-load strobe
  always_comb begin
    stateNext = stateR;
    loadRes   = 1'b0;
    case (stateR)
      IDLE: begin
        if (in_valid) begin
`ifdef ALU_ITER_MUL_EN
          if (opCode == OP_MUL) begin
            stateNext = BUSY;
          end else begin
            loadRes   = 1'b1;
            stateNext = DONE;
          end
`else
          loadRes   = 1'b1;
          stateNext = DONE;
`endif
        end else begin
          stateNext = IDLE;
        end
      end
`ifdef ALU_ITER_MUL_EN
      BUSY: begin
        if (mulDone) begin
          loadRes   = 1'b1;
          stateNext = DONE;
        end else begin
          stateNext = BUSY;
        end
      end
`endif
      DONE: begin
        if (out_ready) begin
          stateNext = IDLE;
        end else begin
          stateNext = DONE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Single-cycle operations; anything unrecognised flags err with ans = 0
  always_comb begin
    sum    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cOptional};
    // Bit WIDTH of the extended difference is the borrow: a < b + bin
    diff   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cOptional};
    aluAns = {WIDTH{1'b0}};
    aluOpt = 1'b0;
    aluErr = 1'b0;
    case (opCode)
      OP_ADD: begin
        aluAns = sum[WIDTH-1:0];
        aluOpt = sum[WIDTH];
      end
      OP_SUB: begin
        aluAns = diff[WIDTH-1:0];
        aluOpt = diff[WIDTH];
      end
      OP_EQ:  aluAns = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_LT:  aluAns = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_LTU: aluAns = {{(WIDTH-1){1'b0}}, (a < b)};
      default: aluErr = 1'b1;
    endcase
  end

  // Result source: multiplier product when finishing a multiply, else ALU
  always_comb begin
    nextAns = aluAns;
    nextOpt = aluOpt;
    nextErr = aluErr;
`ifdef ALU_ITER_MUL_EN
    if (stateR == BUSY) begin
      nextAns = product[WIDTH-1:0];
      nextOpt = |product[2*WIDTH-1:WIDTH];
      nextErr = 1'b0;
    end else begin
      nextAns = aluAns;
      nextOpt = aluOpt;
      nextErr = aluErr;
    end
`endif
  end

  // Result registers, held stable through DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ansR <= {WIDTH{1'b0}};
      optR <= 1'b0;
      zR   <= 1'b0;
      nR   <= 1'b0;
      errR <= 1'b0;
    end else if (loadRes) begin
      ansR <= nextAns;
      optR <= nextOpt;
      zR   <= (nextAns == {WIDTH{1'b0}});
      nR   <= nextAns[WIDTH-1];
      errR <= nextErr;
    end else begin
      ansR <= ansR;
      optR <= optR;
      zR   <= zR;
      nR   <= nR;
      errR <= errR;
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed, table-driven checks of alu_iter (WIDTH = 32)
// plus hand-written sequences for hold, reset-abort and multiply latency.
module tb_alu_iter;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a, b;
  logic [5:0]    opCode;
  logic          cOptional;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  ans;
  logic          ansOptional, z, n, err;

  int checks = 0;
  int errors = 0;

  alu_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opCode(opCode), .cOptional(cOptional),
    .out_valid(out_valid), .out_ready(out_ready), .ans(ans),
    .ansOptional(ansOptional), .z(z), .n(n), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [5:0]   op;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         cin;
    logic [W-1:0] eAns;
    logic         eOpt;
    logic         eZ;
    logic         eN;
    logic         eErr;
  } vecT;

  vecT vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait (bounded) for in_ready, present operands for exactly one edge.
  task automatic doOp(input logic [5:0] op, input logic [W-1:0] va,
                      input logic [W-1:0] vb, input logic cin);
    int w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    chk("in_ready before op", {63'd0, in_ready}, 64'd1);
    opCode = op; a = va; b = vb; cOptional = cin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic chkResult(input string name, input logic [W-1:0] eAns, input logic eOpt,
                           input logic eZ, input logic eN, input logic eErr);
    chk({name, " out_valid"}, {63'd0, out_valid}, 64'd1);
    chk({name, " ans"}, {32'd0, ans}, {32'd0, eAns});
    chk({name, " ansOptional"}, {63'd0, ansOptional}, {63'd0, eOpt});
    chk({name, " z"}, {63'd0, z}, {63'd0, eZ});
    chk({name, " n"}, {63'd0, n}, {63'd0, eN});
    chk({name, " err"}, {63'd0, err}, {63'd0, eErr});
  endtask

  initial begin
    logic [W-1:0] holdAns;
    int           seen;

    //             name        op         a             b             cin   ans           opt   z     n     err
    vecs.push_back('{"add_wrap",  6'b010000, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{"add_cin",   6'b010000, 32'h00000002, 32'h00000003, 1'b1, 32'h00000006, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"add_max",   6'b010000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{"sub_neg",   6'b010001, 32'h00000005, 32'h00000007, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{"sub_bin",   6'b010001, 32'h0000000A, 32'h00000003, 1'b1, 32'h00000006, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"sub_eqbin", 6'b010001, 32'h00000005, 32'h00000005, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{"eq_true",   6'b100000, 32'h00000007, 32'h00000007, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"eq_false",  6'b100000, 32'h00000007, 32'h00000008, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{"lt_neg",    6'b100001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"ltu_big",   6'b100010, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{"lt_pos",    6'b100001, 32'h00000001, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{"ltu_small", 6'b100010, 32'h00000001, 32'hFFFFFFFF, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"ill_3f",    6'b111111, 32'h12345678, 32'h9ABCDEF0, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{"ill_12",    6'b010010, 32'h00000004, 32'h00000004, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1});
`ifndef ALU_ITER_MUL_EN
    vecs.push_back('{"mul_off",   6'b110000, 32'h00000003, 32'h00000005, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1});
`endif

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; opCode = 6'd0; cOptional = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset ans", {32'd0, ans}, 64'd0);
    chk("reset flags", {60'd0, ansOptional, z, n, err}, 64'd0);
    @(posedge clk); #1;

    // Table: single-cycle ops, out_valid expected right after the accept edge
    foreach (vecs[i]) begin
      doOp(vecs[i].op, vecs[i].va, vecs[i].vb, vecs[i].cin);
      chkResult(vecs[i].name, vecs[i].eAns, vecs[i].eOpt, vecs[i].eZ, vecs[i].eN, vecs[i].eErr);
      chk({vecs[i].name, " in_ready busy"}, {63'd0, in_ready}, 64'd0);
      consume();
      chk({vecs[i].name, " back idle"}, {62'd0, in_ready, out_valid}, 64'd2);
    end

    // Hold in DONE for 5 cycles with a competing request on the inputs
    doOp(6'b010000, 32'h00000001, 32'h00000001, 1'b0);
    holdAns = ans;
    chk("hold first ans", {32'd0, holdAns}, 64'd2);
    opCode = 6'b010001; a = 32'h00000009; b = 32'h00000001; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("hold ans", {32'd0, ans}, 64'd2);
      chk("hold hs", {62'd0, out_valid, in_ready}, 64'd2);
    end
    in_valid = 1'b0;
    consume();
    chk("hold release", {62'd0, in_ready, out_valid}, 64'd2);

    // Reset while in DONE: result withdrawn, nothing presented afterwards
    doOp(6'b010000, 32'h00000001, 32'h00000002, 1'b0);
    chk("done-rst pre", {63'd0, out_valid}, 64'd1);
    rst = 1'b1; #1;
    chk("done-rst ans", {32'd0, ans}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("done-rst no result", seen, 64'd0);
    doOp(6'b010000, 32'h00000002, 32'h00000002, 1'b0);
    chkResult("add_after_rst", 32'h00000004, 1'b0, 1'b0, 1'b0, 1'b0);
    consume();

`ifdef ALU_ITER_MUL_EN
    // Multiply latency and overflow
    doOp(6'b110000, 32'h00010000, 32'h00010000, 1'b0);
    seen = 1;
    while (!out_valid && seen < 100) begin
      @(posedge clk); #1; seen++;
    end
    chk("mul latency", seen - 1, 64'd33);
    chkResult("mul_ovf", 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0);
    consume();

    doOp(6'b110000, 32'h00000003, 32'h00000005, 1'b0);
    seen = 1;
    while (!out_valid && seen < 100) begin
      @(posedge clk); #1; seen++;
    end
    chk("mul3x5 latency", seen - 1, 64'd33);
    chkResult("mul_3x5", 32'h0000000F, 1'b0, 1'b0, 1'b0, 1'b0);
    consume();

    // Reset at BUSY cycle 10 aborts the multiply
    doOp(6'b110000, 32'h00000003, 32'h00000005, 1'b0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("busy-rst no result", seen, 64'd0);
    doOp(6'b010000, 32'h00000002, 32'h00000002, 1'b0);
    chkResult("add_after_busy_rst", 32'h00000004, 1'b0, 1'b0, 1'b0, 1'b0);
    consume();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
